// File: rtl/motor_cmd_decode.sv
// Decodes a forward/reverse PWM pair into a signed 11-bit motor command,
// evaluated over free-running 1024-cycle windows.
module motor_cmd_decode #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fwd_in,
  input  logic        rev_in,
  output logic [10:0] cmd,
  output logic        vld,
  output logic        brake,
  output logic        err
);

  logic [SYNC_STAGES-1:0] r_fwd_sync;
  logic [SYNC_STAGES-1:0] r_rev_sync;
  logic                   w_s_fwd;
  logic                   w_s_rev;

  logic [9:0]  r_wcnt;
  logic [10:0] r_fcnt;
  logic [10:0] r_rcnt;
  logic [10:0] w_fc;
  logic [10:0] w_rc;
  logic [10:0] w_fc_sat;
  logic [10:0] w_rc_sat;
  logic        w_win_end;

  logic [10:0] w_cmd_nxt;
  logic        w_brake_nxt;
  logic        w_err_nxt;

  logic [10:0] r_cmd;
  logic        r_vld;
  logic        r_brake;
  logic        r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_sync <= '0;
      r_rev_sync <= '0;
    end else begin
      r_fwd_sync[0] <= fwd_in;
      r_rev_sync[0] <= rev_in;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        r_fwd_sync[i] <= r_fwd_sync[i-1];
        r_rev_sync[i] <= r_rev_sync[i-1];
      end
    end
  end

  assign w_s_fwd   = r_fwd_sync[SYNC_STAGES-1];
  assign w_s_rev   = r_rev_sync[SYNC_STAGES-1];
  assign w_win_end = (r_wcnt == 10'd1023);

  // Final counts include the sample taken on the last window cycle.
  assign w_fc     = r_fcnt + {10'd0, w_s_fwd};
  assign w_rc     = r_rcnt + {10'd0, w_s_rev};
  assign w_fc_sat = w_fc[10] ? 11'd1023 : w_fc;
  assign w_rc_sat = w_rc[10] ? 11'd1023 : w_rc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wcnt <= '0;
      r_fcnt <= '0;
      r_rcnt <= '0;
    end else begin
      r_wcnt <= r_wcnt + 10'd1;
      if (w_win_end) begin
        r_fcnt <= '0;
        r_rcnt <= '0;
      end else begin
        r_fcnt <= w_fc;
        r_rcnt <= w_rc;
      end
    end
  end

  always_comb begin
    w_cmd_nxt   = r_cmd;
    w_brake_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    if (w_fc == 11'd1024 && w_rc == 11'd1024) begin
      w_cmd_nxt   = '0;
      w_brake_nxt = 1'b1;
    end else if (w_fc == '0 && w_rc == '0) begin
      w_cmd_nxt = '0;
    end else if (w_rc == '0) begin
      w_cmd_nxt = w_fc_sat;
    end else if (w_fc == '0) begin
      w_cmd_nxt = 11'd0 - w_rc_sat;
    end else begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd   <= '0;
      r_vld   <= 1'b0;
      r_brake <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_vld <= w_win_end;
      if (w_win_end) begin
        r_cmd   <= w_cmd_nxt;
        r_brake <= w_brake_nxt;
        r_err   <= w_err_nxt;
      end
    end
  end

  assign cmd   = r_cmd;
  assign vld   = r_vld;
  assign brake = r_brake;
  assign err   = r_err;

endmodule
